id_ex_stage: RTL and testbench

// - ID/EX pipeline register for the RV32I pipeline; sits directly upstream of the ALU and drives its A, B, ALUcontrol.
// - Captures decoded instruction fields once per cycle and resolves operand forwarding from EX/MEM and MEM/WB.
// - Detects load-use hazards, stalls IF/ID and inserts a bubble. Flushes on a taken branch.

---
 rtl/rv32_pkg.sv | 24 ++
 rtl/fwd_unit.sv | 52 +++++
 rtl/id_ex_stage.sv | 132 +++++++++++++
 tb/tb_id_ex_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: datapath widths, ALU opcodes and the
// operand-forwarding source select.
package rv32_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;

  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_EXM  = 2'd1,
    FWD_MWB  = 2'd2,
    FWD_ZERO = 2'd3
  } fwd_sel_t;

endpackage

// File: rtl/fwd_unit.sv
// Combinational operand forwarding for rs1/rs2: x0 -> 0, then EX/MEM,
// then MEM/WB, then register-file data.
module fwd_unit
  import rv32_pkg::fwd_sel_t, rv32_pkg::FWD_RF, rv32_pkg::FWD_EXM,
         rv32_pkg::FWD_MWB, rv32_pkg::FWD_ZERO;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_reg_write,
  input  logic [XLEN-1:0]   exm_result,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic              mwb_reg_write,
  input  logic [XLEN-1:0]   mwb_result,
  output logic [XLEN-1:0]   fwd_rs1,
  output logic [XLEN-1:0]   fwd_rs2
);

  logic [1:0][REG_AW-1:0] rs;
  logic [1:0][XLEN-1:0]   rf;
  logic [1:0][XLEN-1:0]   fwd;

  assign rs = {rs2, rs1};
  assign rf = {rs2_data, rs1_data};

  for (genvar i = 0; i < 2; i++) begin : g_src
    fwd_sel_t sel;

    always_comb begin
      sel = FWD_RF;
      if (rs[i] == '0)
        sel = FWD_ZERO;
      else if (exm_reg_write && exm_rd != '0 && exm_rd == rs[i])
        sel = FWD_EXM;
      else if (mwb_reg_write && mwb_rd != '0 && mwb_rd == rs[i])
        sel = FWD_MWB;
    end

    assign fwd[i] = (sel == FWD_EXM)  ? exm_result :
                    (sel == FWD_MWB)  ? mwb_result :
                    (sel == FWD_ZERO) ? '0         : rf[i];
  end

  assign fwd_rs1 = fwd[0];
  assign fwd_rs2 = fwd[1];

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwarded operand capture, load-use stall and
// bubble insertion on stall, flush or an empty decode slot.
module id_ex_stage
  import rv32_pkg::ALU_ADD;
#(
  parameter int XLEN   = rv32_pkg::XLEN,
  parameter int REG_AW = rv32_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_alu_src,
  input  logic [3:0]        id_alu_ctrl,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_reg_write,
  input  logic [XLEN-1:0]   exm_result,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic              mwb_reg_write,
  input  logic [XLEN-1:0]   mwb_result,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_A,
  output logic [XLEN-1:0]   ex_B,
  output logic [3:0]        ex_alu_ctrl,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch
);

  logic [XLEN-1:0]   fwd_rs1, fwd_rs2;
  logic              valid_d, valid_q;
  logic [XLEN-1:0]   a_d, a_q, b_d, b_q, st_d, st_q, pc_d, pc_q;
  logic [3:0]        ctrl_d, ctrl_q;
  logic [REG_AW-1:0] rd_d, rd_q;
  logic              rw_d, rw_q, mr_d, mr_q, mw_d, mw_q, br_d, br_q;

  fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd (
    .rs1(id_rs1), .rs2(id_rs2),
    .rs1_data(id_rs1_data), .rs2_data(id_rs2_data),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2)
  );

  // rs2 only matters when it feeds the ALU or supplies store data.
  assign stall = rst_n && id_valid && !flush && valid_q && mr_q && rd_q != '0 &&
                 (rd_q == id_rs1 || (rd_q == id_rs2 && (!id_alu_src || id_mem_write)));

  always_comb begin
    valid_d = 1'b0;
    a_d     = '0;
    b_d     = '0;
    st_d    = '0;
    pc_d    = '0;
    ctrl_d  = ALU_ADD;
    rd_d    = '0;
    rw_d    = 1'b0;
    mr_d    = 1'b0;
    mw_d    = 1'b0;
    br_d    = 1'b0;
    if (id_valid && !flush && !stall) begin
      valid_d = 1'b1;
      a_d     = fwd_rs1;
      b_d     = id_alu_src ? id_imm : fwd_rs2;
      st_d    = fwd_rs2;
      pc_d    = id_pc;
      ctrl_d  = id_alu_ctrl;
      rd_d    = id_rd;
      rw_d    = id_reg_write;
      mr_d    = id_mem_read;
      mw_d    = id_mem_write;
      br_d    = id_branch;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      st_q    <= '0;
      pc_q    <= '0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      br_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      st_q    <= st_d;
      pc_q    <= pc_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      br_q    <= br_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_A          = a_q;
  assign ex_B          = b_q;
  assign ex_store_data = st_q;
  assign ex_pc         = pc_q;
  assign ex_alu_ctrl   = ctrl_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = rw_q;
  assign ex_mem_read   = mr_q;
  assign ex_mem_write  = mw_q;
  assign ex_branch     = br_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: table of single-cycle capture vectors plus
// hand-written reset, load-use, store-hazard and flush sequences.
module tb_id_ex_stage;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_alu_src;
  logic [3:0]  id_alu_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic [4:0]  exm_rd, mwb_rd;
  logic        exm_reg_write, mwb_reg_write;
  logic [31:0] exm_result, mwb_result;
  logic        flush;
  logic        stall, ex_valid;
  logic [31:0] ex_A, ex_B, ex_store_data, ex_pc;
  logic [3:0]  ex_alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
    .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [31:0] d1;
    logic [4:0]  rs2;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        src;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rw, mr, mw, br;
    logic [4:0]  exm_rd;
    logic        exm_rw;
    logic [31:0] exm_res;
    logic [4:0]  mwb_rd;
    logic        mwb_rw;
    logic [31:0] mwb_res;
    logic        flush;
  } in_t;

  typedef struct {
    in_t         i;
    logic        e_valid;
    logic [31:0] e_a, e_b, e_st;
    logic [3:0]  e_ctrl;
    logic [4:0]  e_rd;
    logic        e_rw, e_mw;
  } vec_t;

  function automatic in_t mk(
    input logic valid, input logic [31:0] pc,
    input logic [4:0] rs1, input logic [31:0] d1,
    input logic [4:0] rs2, input logic [31:0] d2,
    input logic [31:0] imm, input logic src, input logic [3:0] ctrl,
    input logic [4:0] rd, input logic rw, input logic mr, input logic mw, input logic br,
    input logic [4:0] xrd, input logic xrw, input logic [31:0] xres,
    input logic [4:0] wrd, input logic wrw, input logic [31:0] wres,
    input logic fl);
    in_t r;
    r.valid = valid; r.pc = pc; r.rs1 = rs1; r.d1 = d1; r.rs2 = rs2; r.d2 = d2;
    r.imm = imm; r.src = src; r.ctrl = ctrl; r.rd = rd;
    r.rw = rw; r.mr = mr; r.mw = mw; r.br = br;
    r.exm_rd = xrd; r.exm_rw = xrw; r.exm_res = xres;
    r.mwb_rd = wrd; r.mwb_rw = wrw; r.mwb_res = wres; r.flush = fl;
    return r;
  endfunction

  task automatic drive(input in_t v);
    id_valid = v.valid; id_pc = v.pc; id_rs1 = v.rs1; id_rs1_data = v.d1;
    id_rs2 = v.rs2; id_rs2_data = v.d2; id_imm = v.imm; id_alu_src = v.src;
    id_alu_ctrl = v.ctrl; id_rd = v.rd; id_reg_write = v.rw; id_mem_read = v.mr;
    id_mem_write = v.mw; id_branch = v.br;
    exm_rd = v.exm_rd; exm_reg_write = v.exm_rw; exm_result = v.exm_res;
    mwb_rd = v.mwb_rd; mwb_reg_write = v.mwb_rw; mwb_result = v.mwb_res;
    flush = v.flush;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vec[8];
  in_t  lw, dep;

  initial begin
    // fwd priority, then EX/MEM dropped, x0, immediate, mixed rs1/rs2 sources
    vec[0] = '{mk(1, 32'h40, 5, 32'h11, 6, 32'h22, 0, 0, ALU_ADD, 7, 1, 0, 0, 0,
                 5, 1, 32'hAAAA0000, 5, 1, 32'h1234, 0),
               1, 32'hAAAA0000, 32'h22, 32'h22, ALU_ADD, 7, 1, 0};
    vec[1] = '{mk(1, 32'h44, 5, 32'h11, 6, 32'h22, 0, 0, ALU_ADD, 7, 1, 0, 0, 1,
                 5, 0, 32'hAAAA0000, 5, 1, 32'h1234, 0),
               1, 32'h1234, 32'h22, 32'h22, ALU_ADD, 7, 1, 0};
    vec[2] = '{mk(1, 32'h48, 0, 32'hFFFFFFFF, 0, 32'h5, 0, 0, ALU_AND, 8, 1, 0, 0, 0,
                 0, 1, 32'hDEAD, 0, 1, 32'hBEEF, 0),
               1, 32'h0, 32'h0, 32'h0, ALU_AND, 8, 1, 0};
    vec[3] = '{mk(1, 32'h4C, 1, 32'h100, 2, 32'h7, 32'hFFFFFFFC, 1, ALU_SUB, 0, 0, 0, 1, 0,
                 0, 0, 0, 0, 0, 0, 0),
               1, 32'h100, 32'hFFFFFFFC, 32'h7, ALU_SUB, 0, 0, 1};
    vec[4] = '{mk(1, 32'h50, 10, 32'h1, 9, 32'h2, 0, 0, ALU_XOR, 11, 1, 0, 0, 0,
                 9, 1, 32'h77, 10, 1, 32'h99, 0),
               1, 32'h99, 32'h77, 32'h77, ALU_XOR, 11, 1, 0};
    vec[5] = '{mk(1, 32'h54, 1, 32'h1, 2, 32'h2, 0, 0, ALU_OR, 12, 1, 0, 1, 1,
                 0, 0, 0, 0, 0, 0, 1),
               0, 0, 0, 0, ALU_ADD, 0, 0, 0};
    vec[6] = '{mk(0, 32'h58, 1, 32'h1, 2, 32'h2, 0, 0, ALU_SLL, 13, 1, 0, 1, 0,
                 0, 0, 0, 0, 0, 0, 0),
               0, 0, 0, 0, ALU_ADD, 0, 0, 0};
    vec[7] = '{mk(1, 32'h5C, 4, 32'h4444, 4, 32'h4444, 0, 0, ALU_SRA, 14, 1, 0, 0, 0,
                 0, 0, 0, 4, 0, 32'h1, 0),
               1, 32'h4444, 32'h4444, 32'h4444, ALU_SRA, 14, 1, 0};

    // Reset held 2 cycles with a real instruction in decode
    rst_n = 1'b0;
    drive(mk(1, 32'h10, 1, 32'h1, 2, 32'h2, 32'h3, 0, ALU_SUB, 4, 1, 1, 1, 1,
             0, 0, 0, 0, 0, 0, 0));
    tick(); tick();
    chk("rst_valid", ex_valid, 0);
    chk("rst_A", ex_A, 0);
    chk("rst_B", ex_B, 0);
    chk("rst_store", ex_store_data, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_ctrl", ex_alu_ctrl, ALU_AND);
    chk("rst_rd", ex_rd, 0);
    chk("rst_ctl_bits", {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 0);
    chk("rst_stall", stall, 0);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      drive(vec[k].i);
      #1 chk($sformatf("v%0d_stall", k), stall, 0);
      tick();
      chk($sformatf("v%0d_valid", k), ex_valid, vec[k].e_valid);
      chk($sformatf("v%0d_A", k), ex_A, vec[k].e_a);
      chk($sformatf("v%0d_B", k), ex_B, vec[k].e_b);
      chk($sformatf("v%0d_store", k), ex_store_data, vec[k].e_st);
      chk($sformatf("v%0d_ctrl", k), ex_alu_ctrl, vec[k].e_ctrl);
      chk($sformatf("v%0d_rd", k), ex_rd, vec[k].e_rd);
      chk($sformatf("v%0d_rw", k), ex_reg_write, vec[k].e_rw);
      chk($sformatf("v%0d_mw", k), ex_mem_write, vec[k].e_mw);
      chk($sformatf("v%0d_pc", k), ex_pc, vec[k].e_valid ? vec[k].i.pc : 32'h0);
      chk($sformatf("v%0d_br", k), ex_branch, vec[k].e_valid ? vec[k].i.br : 1'b0);
    end

    // Load-use on rs1: one stall cycle, bubble, then replay with forwarded load data
    lw  = mk(1, 32'h100, 1, 32'h1000, 0, 0, 32'h4, 1, ALU_ADD, 3, 1, 1, 0, 0,
             0, 0, 0, 0, 0, 0, 0);
    dep = mk(1, 32'h104, 3, 32'hBAD, 4, 32'h10, 0, 0, ALU_ADD, 5, 1, 0, 0, 0,
             0, 0, 0, 0, 0, 0, 0);
    drive(lw); tick();
    chk("lu_ex_mem_read", ex_mem_read, 1);
    chk("lu_ex_rd", ex_rd, 3);
    drive(dep);
    #1 chk("lu_stall", stall, 1);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_ctrl", ex_alu_ctrl, ALU_ADD);
    chk("lu_bubble_rw", ex_reg_write, 0);
    chk("lu_bubble_rd", ex_rd, 0);
    chk("lu_stall_once", stall, 0);
    dep.mwb_rd = 3; dep.mwb_rw = 1; dep.mwb_res = 32'h55;
    drive(dep); tick();
    chk("lu_replay_valid", ex_valid, 1);
    chk("lu_replay_A", ex_A, 32'h55);
    chk("lu_replay_B", ex_B, 32'h10);

    // Store with loaded rs2 stalls; immediate-op with same rs2 does not
    drive(lw); tick();
    dep = mk(1, 32'h108, 1, 32'h1, 3, 32'h2, 32'h8, 1, ALU_ADD, 0, 0, 0, 1, 0,
             0, 0, 0, 0, 0, 0, 0);
    drive(dep);
    #1 chk("st_rs2_stall", stall, 1);
    dep.mw = 0; dep.rw = 1; dep.rd = 6;
    drive(dep);
    #1 chk("imm_rs2_nostall", stall, 0);

    // Flush together with a load-use hazard: no stall, bubble captured
    dep = mk(1, 32'h10C, 3, 32'h1, 0, 0, 0, 0, ALU_ADD, 7, 1, 0, 1, 0,
             0, 0, 0, 0, 0, 0, 1);
    drive(dep);
    #1 chk("flush_stall", stall, 0);
    tick();
    chk("flush_valid", ex_valid, 0);
    chk("flush_mw", ex_mem_write, 0);
    chk("flush_rw", ex_reg_write, 0);

    // Reset during a stall: stall drops immediately, registers clear to reset values
    drive(lw); tick();
    dep.flush = 0; dep.mw = 0;
    drive(dep);
    #1 chk("mid_stall_pre", stall, 1);
    rst_n = 1'b0;
    #1 chk("mid_stall_rst", stall, 0);
    tick();
    chk("mid_rst_valid", ex_valid, 0);
    chk("mid_rst_ctrl", ex_alu_ctrl, ALU_AND);
    chk("mid_rst_mr", ex_mem_read, 0);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
